// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit
// common-anode seven-segment display.
//
// A full frame (digits, enable mask, decimal points) is written into
// shadow registers by a load strobe. It is copied to the active registers
// only when the digit index wraps from 7 to 0, so a frame never mixes old
// and new digits.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When it is defined, leading zeros in the active frame are blanked.
//   Digit 0 is never blanked.
//   When it is undefined, only en_mask blanks a digit.
module seg_scan_ctrl #(
  parameter  int PRESCALE = 100000,
  localparam int CNT_W    = $clog2(PRESCALE + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] digits_in,
  input  logic [7:0]  en_mask,
  input  logic [7:0]  dp_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             pending_q;
  logic [31:0]      sh_dig_q, act_dig_q;
  logic [7:0]       sh_mask_q, act_mask_q;
  logic [7:0]       sh_dp_q, act_dp_q;

  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q;

  logic             tick;
  logic             wrap;
  logic [3:0]       cur_digit;
  logic [6:0]       cur_pattern;
  logic [7:0]       blank_lz;
  logic             lit;

  assign tick = (cnt_q == CNT_W'(PRESCALE - 1));
  assign wrap = tick && (idx_q == 3'd7);

  // Prescaler and digit index next-state.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Scan timing: the prescaler and the digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Shadow capture, pending flag, and the commit into active registers at wrap.
  // A commit on a wrap edge uses the shadow contents from before that edge.
  // A load on the same edge refills the shadow and keeps pending set.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= 1'b0;
      sh_dig_q   <= '0;
      sh_mask_q  <= '0;
      sh_dp_q    <= '0;
      act_dig_q  <= '0;
      act_mask_q <= '0;
      act_dp_q   <= '0;
    end else begin
      if (wrap && pending_q) begin
        act_dig_q  <= sh_dig_q;
        act_mask_q <= sh_mask_q;
        act_dp_q   <= sh_dp_q;
        pending_q  <= 1'b0;
      end
      if (load) begin
        sh_dig_q  <= digits_in;
        sh_mask_q <= en_mask;
        sh_dp_q   <= dp_in;
        pending_q <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // Blank a zero digit when every enabled digit above it is also zero.
  always_comb begin
    blank_lz   = '0;
    upper_zero = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      if (upper_zero && (act_dig_q[4*k +: 4] == 4'd0))
        blank_lz[k] = 1'b1;
      if (act_mask_q[k] && (act_dig_q[4*k +: 4] != 4'd0))
        upper_zero = 1'b0;
    end
  end
`else
  assign blank_lz = '0;
`endif

  assign cur_digit = act_dig_q[{idx_q, 2'b00} +: 4];
  assign lit       = act_mask_q[idx_q] && !blank_lz[idx_q];

  // BCD to active-low {g,f,e,d,c,b,a}. Values 10 to 15 show a dash.
  always_comb begin
    cur_pattern = 7'b0111111;
    case (cur_digit)
      4'd0: cur_pattern = 7'b1000000;
      4'd1: cur_pattern = 7'b1111001;
      4'd2: cur_pattern = 7'b0100100;
      4'd3: cur_pattern = 7'b0110000;
      4'd4: cur_pattern = 7'b0011001;
      4'd5: cur_pattern = 7'b0010010;
      4'd6: cur_pattern = 7'b0000010;
      4'd7: cur_pattern = 7'b1111000;
      4'd8: cur_pattern = 7'b0000000;
      4'd9: cur_pattern = 7'b0010000;
      default: cur_pattern = 7'b0111111;
    endcase
  end

  // Output next-state. A dark anode also forces the segments and the decimal point off.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = cur_pattern;
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  // Registered outputs and the frame_done pulse after each wrap edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= wrap;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with PRESCALE = 4.
// The driver runs a timeline-level reference model and queues the expected
// outputs for each edge. The monitor pops one entry after every edge and
// compares it with the DUT outputs.
module tb_seg_scan_ctrl;

  localparam int P  = 4;
  localparam int FR = 8 * P;
  localparam logic [6:0] DEC [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0]  en_mask = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seg_scan_ctrl #(.PRESCALE(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .digits_in  (digits_in),
    .en_mask    (en_mask),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a count of edges since reset, plus the frame registers.
  int          m_e = 0;
  logic [31:0] sh_d = '0, ac_d = '0;
  logic [7:0]  sh_m = '0, ac_m = '0, sh_p = '0, ac_p = '0;
  bit          pend = 0;

  function automatic logic [3:0] nib(input logic [31:0] w, input int k);
    return w[4*k +: 4];
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] v);
    if (v <= 4'd9) return DEC[v];
    return 7'b0111111;
  endfunction

  function automatic bit shown(input int k);
    if (!ac_m[k]) return 0;
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && nib(ac_d, k) == 4'd0) begin
      bit all_zero = 1;
      for (int j = k + 1; j < 8; j++)
        if (ac_m[j] && nib(ac_d, j) != 4'd0) all_zero = 0;
      if (all_zero) return 0;
    end
`endif
    return 1;
  endfunction

  task automatic step(input bit r, input bit ld, input logic [31:0] d,
                      input logic [7:0] m, input logic [7:0] p);
    exp_t e;
    int   k;
    logic [7:0] onehot;
    @(negedge clk);
    reset = r; load = ld; digits_in = d; en_mask = m; dp_in = p;
    @(posedge clk);
    if (r) begin
      e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
      m_e = 0; pend = 0;
      sh_d = '0; sh_m = '0; sh_p = '0; ac_d = '0; ac_m = '0; ac_p = '0;
    end else begin
      k = (m_e / P) % 8;
      e.fd = ((m_e + 1) % FR == 0);
      if (shown(k)) begin
        onehot = 8'h01 << k;
        e.an  = ~onehot;
        e.seg = decode(nib(ac_d, k));
        e.dp  = ~ac_p[k];
      end else begin
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
      end
      if (e.fd && pend) begin
        ac_d = sh_d; ac_m = sh_m; ac_p = sh_p; pend = 0;
      end
      if (ld) begin
        sh_d = d; sh_m = m; sh_p = p; pend = 1;
      end
      m_e++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 8'h0, 8'h0);
  endtask

  // Idle until the next edge is the requested scan position (bounded by one frame).
  task automatic idle_until_pos(input int pos);
    for (int i = 0; i < FR; i++) begin
      if (m_e % FR == pos) break;
      step(0, 0, 32'h0, 8'h0, 8'h0);
    end
  endtask

  // Monitor: after every edge, compare the DUT outputs with the oldest queued expectation.
  initial begin
    exp_t e;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty cycle=%0d got an=%h seg=%b dp=%b fd=%b expected=none",
                 cyc, an, seg, dp, frame_done);
      end else begin
        e = q.pop_front();
        if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
          bad++;
          $display("FAIL scan_out cycle=%0d got an=%h seg=%b dp=%b fd=%b expected an=%h seg=%b dp=%b fd=%b",
                   cyc, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
        end
      end
    end
  end

  // Driver: directed scenarios first, then randomized traffic.
  initial begin
    step(1, 0, 32'h0, 8'h0, 8'h0);
    step(1, 0, 32'h0, 8'h0, 8'h0);
    step(1, 0, 32'h0, 8'h0, 8'h0);
    idle(40);

    step(0, 1, 32'h7654_3210, 8'hFF, 8'h01);
    idle(80);

    step(0, 1, 32'h0000_0A03, 8'h05, 8'h00);
    idle(70);

    step(0, 1, 32'h1122_3344, 8'hFF, 8'hAA);
    idle_until_pos(FR - 1);
    step(0, 1, 32'h9876_5432, 8'hF0, 8'h0F);
    idle(100);

    idle_until_pos(5 * P + 1);
    step(1, 0, 32'h0, 8'h0, 8'h0);
    idle(45);

    step(0, 1, 32'h0000_0105, 8'hFF, 8'h00);
    idle(70);
    step(0, 1, 32'h0000_0000, 8'hFF, 8'h00);
    idle(70);
    step(0, 1, 32'h0300_0000, 8'hBF, 8'h40);
    idle(70);

    for (int i = 0; i < 900; i++) begin
      logic [31:0] d;
      for (int n = 0; n < 8; n++)
        d[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 11) == 0), d,
           8'($urandom), 8'($urandom));
    end

    @(negedge clk);
    load = 1'b0;
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
